// File: rtl/winograd_tile_scheduler.sv
// Winograd tile scheduler: walks a TR x TC tile grid, handshaking each tile with the engine.
// Define TILE_SCHED_TIMEOUT_EN to add the PROCESS-state watchdog.
module winograd_tile_scheduler #(
  parameter int W       = 10,
  parameter int H       = 10,
  parameter int n       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_tile_ready,
  input  logic        i_proc_done,
  output logic        o_proc_start,
  output logic        o_proc_finish,
  output logic [15:0] o_tile_row,
  output logic [15:0] o_tile_col,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_timeout
);

  localparam int TC = (W - 2) / (n - 2);
  localparam int TR = (H - 2) / (n - 2);
  localparam logic [15:0] LAST_C = 16'(TC - 1);
  localparam logic [15:0] LAST_R = 16'(TR - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TILE,
    ISSUE,
    PROCESS,
    ADVANCE,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] row_nx;
  logic [15:0] col_nx;
  logic        tmo_hit;

`ifdef TILE_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  // Fires on the TIMEOUT-th PROCESS cycle without a done pulse.
  assign tmo_hit = (state == PROCESS) && !i_proc_done &&
                   (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt <= '0;
    end else if (state == PROCESS && state_nx == PROCESS) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_timeout <= 1'b0;
    end else if (!i_abort && tmo_hit) begin
      o_timeout <= 1'b1;
    end else if (!i_abort && state == IDLE && i_start) begin
      o_timeout <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
  assign o_timeout      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    row_nx   = o_tile_row;
    col_nx   = o_tile_col;
    if (i_abort) begin
      state_nx = IDLE;
      row_nx   = '0;
      col_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state_nx = WAIT_TILE;
            row_nx   = '0;
            col_nx   = '0;
          end
        end
        WAIT_TILE: begin
          if (i_tile_ready) state_nx = ISSUE;
        end
        ISSUE: state_nx = PROCESS;
        PROCESS: begin
          if (i_proc_done || tmo_hit) state_nx = ADVANCE;
        end
        ADVANCE: begin
          if (o_tile_row == LAST_R && o_tile_col == LAST_C) begin
            state_nx = DONE;
            row_nx   = '0;
            col_nx   = '0;
          end else if (o_tile_col == LAST_C) begin
            state_nx = WAIT_TILE;
            row_nx   = o_tile_row + 16'd1;
            col_nx   = '0;
          end else begin
            state_nx = WAIT_TILE;
            col_nx   = o_tile_col + 16'd1;
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Pulses decode the next state so they line up with the state they mark.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_tile_row    <= '0;
      o_tile_col    <= '0;
      o_busy        <= 1'b0;
      o_proc_start  <= 1'b0;
      o_proc_finish <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      state         <= state_nx;
      o_tile_row    <= row_nx;
      o_tile_col    <= col_nx;
      o_busy        <= (state_nx != IDLE);
      o_proc_start  <= (state_nx == ISSUE);
      o_proc_finish <= (state_nx == ADVANCE);
      o_frame_done  <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Directed bench for winograd_tile_scheduler: vector table plus frame-level sequences.
// Honours TILE_SCHED_TIMEOUT_EN for the watchdog scenario.
module tb_winograd_tile_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic        i_tile_ready = 1'b0;
  logic        i_proc_done = 1'b0;
  logic        o_proc_start;
  logic        o_proc_finish;
  logic [15:0] o_tile_row;
  logic [15:0] o_tile_col;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_timeout;

  int checks = 0;
  int failures = 0;
  int tiles;
  int frames;
  int finishes;

  always #5 i_clk = ~i_clk;

  winograd_tile_scheduler dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_tile_ready (i_tile_ready),
    .i_proc_done  (i_proc_done),
    .o_proc_start (o_proc_start),
    .o_proc_finish(o_proc_finish),
    .o_tile_row   (o_tile_row),
    .o_tile_col   (o_tile_col),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_timeout    (o_timeout)
  );

  typedef struct {
    logic        start;
    logic        abort;
    logic        ready;
    logic        done;
    logic        busy;
    logic        pstart;
    logic        finish;
    logic        fdone;
    logic [15:0] row;
    logic [15:0] col;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic abort_cycle();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
  endtask

  // Engine model: done pulse two cycles after each observed proc_start.
  task automatic run_tiles(input int stop_at, input int poke_at,
                           input int budget);
    int cd;
    bit ended;
    cd = 0;
    ended = 1'b0;
    tiles = 0;
    frames = 0;
    finishes = 0;
    i_tile_ready = 1'b1;
    i_proc_done = 1'b0;
    for (int c = 0; c < budget && !ended; c++) begin
      i_proc_done = (cd == 1);
      if (cd > 0) cd--;
      step();
      i_start = 1'b0;
      if (o_proc_finish) finishes++;
      if (o_proc_start) begin
        chk($sformatf("tile%0d_row", tiles), o_tile_row, tiles / 4);
        chk($sformatf("tile%0d_col", tiles), o_tile_col, tiles % 4);
        if (tiles == poke_at) i_start = 1'b1;
        if (tiles == stop_at) ended = 1'b1;
        else tiles++;
        cd = 2;
      end
      if (o_frame_done) begin
        frames++;
        ended = 1'b1;
      end
    end
    i_proc_done = 1'b0;
    i_start = 1'b0;
    if (!ended) begin
      checks++;
      failures++;
      $display("FAIL run_budget: expired after %0d cycles, required end", budget);
    end
  endtask

  initial begin
    bit   seen;
    bit   low;
    int   k;

    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0};
    vecs[1]  = '{1, 0, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0};
    vecs[2]  = '{0, 0, 0, 0, 1, 0, 0, 0, 16'd0, 16'd0};
    vecs[3]  = '{0, 0, 1, 0, 1, 1, 0, 0, 16'd0, 16'd0};
    vecs[4]  = '{0, 0, 1, 0, 1, 0, 0, 0, 16'd0, 16'd0};
    vecs[5]  = '{0, 0, 0, 1, 1, 0, 1, 0, 16'd0, 16'd0};
    vecs[6]  = '{0, 0, 0, 1, 1, 0, 0, 0, 16'd0, 16'd1};
    vecs[7]  = '{1, 0, 1, 0, 1, 1, 0, 0, 16'd0, 16'd1};
    vecs[8]  = '{0, 0, 0, 1, 1, 0, 0, 0, 16'd0, 16'd1};
    vecs[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 16'd0, 16'd1};
    vecs[10] = '{0, 0, 0, 1, 1, 0, 1, 0, 16'd0, 16'd1};
    vecs[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 16'd0, 16'd2};
    vecs[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0};

    #12;
    chk("reset_outputs",
        {o_busy, o_proc_start, o_proc_finish, o_frame_done, o_timeout,
         o_tile_row, o_tile_col}, 0);
    #1 i_rst_n = 1'b1;
    step();
    chk("idle_after_reset", {o_busy, o_proc_start, o_frame_done}, 0);

    for (int i = 0; i < 14; i++) begin
      i_start      = vecs[i].start;
      i_abort      = vecs[i].abort;
      i_tile_ready = vecs[i].ready;
      i_proc_done  = vecs[i].done;
      step();
      chk($sformatf("vec%0d", i),
          {o_busy, o_proc_start, o_proc_finish, o_frame_done,
           o_tile_row, o_tile_col},
          {vecs[i].busy, vecs[i].pstart, vecs[i].finish, vecs[i].fdone,
           vecs[i].row, vecs[i].col});
    end
    i_start = 0;
    i_abort = 0;
    i_tile_ready = 0;
    i_proc_done = 0;

    pulse_start();
    run_tiles(-1, -1, 1000);
    chk("frame_tiles", tiles, 16);
    chk("frame_done_count", frames, 1);
    chk("frame_finishes", finishes, 16);
    step();
    chk("busy_after_frame", o_busy, 0);

    i_tile_ready = 1'b0;
    pulse_start();
    seen = 1'b0;
    low = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_proc_start) seen = 1'b1;
      if (!o_busy) low = 1'b1;
    end
    chk("no_ready_no_start", seen, 0);
    chk("no_ready_busy_drop", low, 0);
    abort_cycle();
    chk("abort_wait_busy", o_busy, 0);

    pulse_start();
    run_tiles(6, -1, 1000);
    step();
    chk("tile12_process", {o_busy, o_proc_start}, 2'b10);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("abort_idle",
        {o_busy, o_proc_finish, o_proc_start, o_tile_row, o_tile_col}, 0);
    step();
    chk("abort_no_finish", {o_busy, o_proc_finish}, 0);
    pulse_start();
    run_tiles(0, -1, 100);
    abort_cycle();

    pulse_start();
    run_tiles(-1, 4, 1000);
    chk("poke_tiles", tiles, 16);
    chk("poke_frames", frames, 1);
    step();
    chk("poke_busy_after", o_busy, 0);

    pulse_start();
    run_tiles(0, -1, 100);
    i_proc_done = 1'b0;
`ifdef TILE_SCHED_TIMEOUT_EN
    k = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      step();
      k++;
      if (o_proc_finish) seen = 1'b1;
    end
    chk("wd_cycles_to_finish", k, 65);
    chk("wd_timeout_set", o_timeout, 1);
    abort_cycle();
    chk("wd_sticky_after_abort", o_timeout, 1);
    pulse_start();
    chk("wd_cleared_by_start", o_timeout, 0);
    abort_cycle();
`else
    k = 0;
    seen = 1'b0;
    low = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (o_proc_finish) seen = 1'b1;
      if (o_timeout || !o_busy) low = 1'b1;
    end
    chk("nowd_no_finish", seen, 0);
    chk("nowd_timeout_busy", low, 0);
    abort_cycle();
`endif

    pulse_start();
    run_tiles(0, -1, 100);
    step();
    i_proc_done = 1'b1;
    step();
    i_proc_done = 1'b0;
    chk("advance_reached", o_proc_finish, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_reset",
        {o_busy, o_proc_start, o_proc_finish, o_frame_done,
         o_tile_row, o_tile_col}, 0);
    #2 i_rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (o_busy || o_proc_start) seen = 1'b1;
    end
    chk("idle_after_reset_release", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
